// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int SUB_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first through one full-subtractor cell,
// with valid/ready handshakes on request and result.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_nb;
  logic             w_accept;
  logic             w_last;

  full_subtractor u_cell (
    .x  (r_a_sh[0]),
    .y  (r_b_sh[0]),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_nb)
  );

  assign w_accept = start_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == LAST_BIT);

  always_comb begin
    w_next      = r_state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) w_next = SHIFT;
      end
      SHIFT: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a_sh   <= a;
        r_b_sh   <= b;
        r_borrow <= bin;
        r_diff   <= '0;
        r_cnt    <= '0;
      end else if (r_state == SHIFT) begin
        // Difference bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
        r_diff   <= (r_diff >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
        r_a_sh   <= r_a_sh >> 1;
        r_b_sh   <= r_b_sh >> 1;
        r_borrow <= w_nb;
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
        if (w_last) r_bout <= w_nb;
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: fixed vectors, handshake corner cases and
// random operations checked against an arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] diff;
  logic         bout;

  int checks;
  int failures;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .diff        (diff),
    .bout        (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer subtraction, wrapped to W bits; borrow when a < b + bin.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] md, output logic mbo);
    int r;
    r   = int'(ma) - int'(mb) - int'(mbin);
    md  = W'(r & ((1 << W) - 1));
    mbo = (int'(ma) < int'(mb) + int'(mbin));
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        input logic [W-1:0] ed, input logic eb,
                        input bit keep_valid, input bit early, input int hold,
                        input string tag);
    int k;
    chk({tag, "_idle_ready"}, start_ready, 1);
    a = ta; b = tb_; bin = tbin; start_valid = 1'b1;
    tick();
    if (!keep_valid) start_valid = 1'b0;
    if (early) res_ready = 1'b1;
    k = 0;
    while (!res_valid && k < 20) begin
      chk({tag, "_busy_ready"}, start_ready, 0);
      if (keep_valid) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      tick();
      k++;
    end
    chk({tag, "_latency"}, k, W);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        chk({tag, "_hold_valid"}, res_valid, 1);
        chk({tag, "_hold_diff"}, diff, ed);
        chk({tag, "_hold_bout"}, bout, eb);
        chk({tag, "_hold_ready"}, start_ready, 0);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    start_valid = 1'b0;
    chk({tag, "_post_ready"}, start_ready, 1);
    chk({tag, "_post_valid"}, res_valid, 0);
    chk({tag, "_keep_diff"}, diff, ed);
    chk({tag, "_keep_bout"}, bout, eb);
  endtask

  initial begin
    logic [W-1:0] md;
    logic         mbo;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;

    checks = 0;
    failures = 0;

    vecs[0] = '{a: 4'd0,  b: 4'd0,  bin: 1'b0, d: 4'b0000, bo: 1'b0};
    vecs[1] = '{a: 4'd7,  b: 4'd5,  bin: 1'b0, d: 4'b0010, bo: 1'b0};
    vecs[2] = '{a: 4'd5,  b: 4'd7,  bin: 1'b0, d: 4'b1110, bo: 1'b1};
    vecs[3] = '{a: 4'd8,  b: 4'd8,  bin: 1'b1, d: 4'b1111, bo: 1'b1};
    vecs[4] = '{a: 4'd15, b: 4'd0,  bin: 1'b1, d: 4'b1110, bo: 1'b0};
    vecs[5] = '{a: 4'd0,  b: 4'd15, bin: 1'b1, d: 4'b0000, bo: 1'b1};

    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    tick();
    chk("rst_start_ready", start_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, 1'b0, 1'b0, 0,
             $sformatf("vec%0d", i));

    // Backpressure: result held for 5 cycles in DONE.
    run_op(4'd15, 4'd15, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 5, "bp");

    // Operands scrambled and start_valid held high during SHIFT and DONE.
    run_op(4'd12, 4'd3, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 2, "stable");

    // Early res_ready has no effect on the result.
    run_op(4'd2, 4'd9, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b1, 0, "early");

    // Reset just before bit 2 of 9-3.
    a = 4'd9; b = 4'd3; bin = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_start_ready", start_ready, 1);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
    run_op(4'd9, 4'd3, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 0, "after_rst");

    // Reset while a result is waiting in DONE discards it.
    a = 4'd1; b = 4'd2; bin = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < W; i++) tick();
    chk("donerst_pre_valid", res_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("donerst_res_valid", res_valid, 0);
    chk("donerst_start_ready", start_ready, 1);
    chk("donerst_diff", diff, 0);
    chk("donerst_bout", bout, 0);
    tick();
    chk("donerst_stay_idle", res_valid, 0);

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      model(ra, rb, rbin, md, mbo);
      run_op(ra, rb, rbin, md, mbo, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing a − b − bin, the inverse arithmetic companion to the team's combinational 4-bit adder (a + b + cin). Operands are captured through a valid/ready request handshake and processed one bit per clock, LSB first, through a single full-subtractor cell. The difference and borrow-out are returned through a valid/ready result handshake. The block sits beside the adder in the datapath test area, where a low-area subtract path is needed.

## Interface
- WIDTH, 4, operand and difference width in bits (≥ 1)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous and active-low; one clock, sampled on the rising edge of clk
- start_valid  input  1  request holds valid operands
- start_ready  output  1  block can accept a request (high only in IDLE)
- a  input  WIDTH  minuend, sampled only on accept
- b  input  WIDTH  subtrahend, sampled only on accept
- bin  input  1  borrow-in, sampled only on accept
- res_valid  output  1  diff/bout hold a completed result
- res_ready  input  1  consumer takes result
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH
- bout  output  1  borrow-out, 1 when a < b + bin (unsigned)

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start_ready=1. On start_valid&&start_ready:
  - load a_sh←a, b_sh←b, borrow←bin;
  - clear diff shift register and bit counter;
  - go to SHIFT.
- SHIFT: each cycle, the cell computes d = a_sh[0]^b_sh[0]^borrow and nb = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow).
  - d shifts into the MSB of the diff register (right shift).
  - a_sh and b_sh shift right; borrow←nb; counter increments.
  - After the WIDTH-th bit: bout←nb, go to DONE.
- DONE: res_valid=1; diff/bout stable.
  - On res_ready: go to IDLE.
  - Otherwise hold indefinitely (backpressure).
- No new request is accepted in SHIFT or DONE. Changes on a/b/bin after accept are ignored.
- Arithmetic is unsigned. Two's-complement interpretation of diff is valid for signed callers; no overflow flag.
- Counter width: $clog2(WIDTH+1) bits. It saturates at WIDTH, with no wrap-around use.

## Timing
- Reset values (first rising edge with rst_n=0): state=IDLE, start_ready=1, res_valid=0, diff=0, bout=0, counter=0. Internal shift registers are cleared to 0.
- Reset mid-operation (SHIFT or DONE) aborts. No result is produced and the pending result is discarded. rst_n has priority over every handshake.
- Latency: the accept edge is T. SHIFT occupies edges T+1..T+WIDTH. res_valid is high from the cycle after edge T+WIDTH, i.e. WIDTH+1 clocks after accept.
- Result hand-off at edge R (res_valid&&res_ready): start_ready is high from the cycle after R. Minimum request-to-request spacing is WIDTH+2 cycles.
- diff and bout change only during SHIFT and at reset. In IDLE they keep the last result.
- res_ready asserted early (before DONE) has no effect.
- WIDTH=1: a single SHIFT cycle; the same rules apply.

## Structure
- Shared package sub_pkg holds:
  - the FSM state encoding as localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - the default width constant SUB_WIDTH=4.
- The natural sub-module is full_subtractor: combinational, 1-bit, ports x, y, bi, d, bo. It is instantiated once; the rest is FSM, counter and shift registers in serial_subtractor.

## Test plan
- Reset, then a=0, b=0, bin=0 -> after WIDTH+1 cycles res_valid=1, diff=4'b0000, bout=0.
- a=7, b=5, bin=0 -> diff=4'b0010, bout=0. a=5, b=7, bin=0 -> diff=4'b1110, bout=1.
- a=8, b=8, bin=1 -> diff=4'b1111, bout=1. a=15, b=0, bin=1 -> diff=4'b1110, bout=0. a=0, b=15, bin=1 -> diff=4'b0000, bout=1.
- Backpressure: a=15, b=15, bin=0, hold res_ready=0 for 5 cycles in DONE -> res_valid stays 1, diff=0000, bout=0 stable, start_ready=0 throughout. Then res_ready=1 -> start_ready=1 next cycle.
- Input stability: change a/b during SHIFT and hold start_valid high -> result reflects only the captured operands, and no second accept occurs before result hand-off.
- Reset mid-SHIFT (rst_n=0 at bit 2 of a=9, b=3) -> next cycle state IDLE, res_valid=0, diff=0, bout=0. A subsequent 9−3−0 yields diff=4'b0110, bout=0.
